// File: rtl/data_mem_responder.sv
// Data-memory responder: byte-addressable word RAM behind a request/ack FSM
// with programmable wait states, misalignment detection and load extension.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic [31:0] rw_addr,
  input  logic [31:0] write_data,
  output logic        mem_ack,
  output logic [31:0] read_data,
  output logic        addr_error
);

  // Handshake: mem_req is sampled only in S_IDLE; the requester holds it until
  // it sees mem_ack (a one-cycle pulse in S_RESP) and drops it on that edge.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WAIT   = 2'b01,
    S_ACCESS = 2'b10,
    S_RESP   = 2'b11
  } state_t;

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wen_q, wen_d;
  logic [1:0]            size_q, size_d;
  logic                  sgn_q, sgn_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [31:0] ram [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]           ram_word;
  logic [31:0]           byte_shift, half_shift;
  logic [31:0]           load_val;
  logic [31:0]           store_word;
  logic [3:0]            store_be;
  logic                  req_err;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^rw_addr[31:ADDR_WIDTH+2];

  assign idx        = addr_q[ADDR_WIDTH+1:2];
  assign ram_word   = ram[idx];
  assign byte_shift = ram_word >> {addr_q[1:0], 3'b000};
  assign half_shift = ram_word >> {addr_q[1], 4'b0000};

  assign req_err = (mem_size == 2'b11) ||
                   (mem_size == 2'b01 && rw_addr[0]) ||
                   (mem_size == 2'b10 && rw_addr[1:0] != 2'b00);

  always_comb begin
    load_val   = ram_word;
    store_word = wdata_q;
    store_be   = 4'b1111;
    case (size_q)
      2'b00: begin
        load_val   = sgn_q ? {{24{byte_shift[7]}}, byte_shift[7:0]}
                           : {24'b0, byte_shift[7:0]};
        store_word = {4{wdata_q[7:0]}};
        store_be   = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        load_val   = sgn_q ? {{16{half_shift[15]}}, half_shift[15:0]}
                           : {16'b0, half_shift[15:0]};
        store_word = {2{wdata_q[15:0]}};
        store_be   = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        load_val   = ram_word;
        store_word = wdata_q;
        store_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          addr_d  = rw_addr[ADDR_WIDTH+1:0];
          wdata_d = write_data;
          wen_d   = mem_wen;
          size_d  = mem_size;
          sgn_d   = mem_signed;
          rdata_d = 32'b0;
          err_d   = req_err;
          cnt_d   = '0;
          if (req_err)              state_d = S_RESP;
          else if (WAIT_CYCLES > 0) state_d = S_WAIT;
          else                      state_d = S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = S_ACCESS;
        else                    cnt_d   = cnt_q + CW'(1);
      end
      S_ACCESS: begin
        rdata_d = wen_q ? 32'b0 : load_val;
        state_d = S_RESP;
      end
      default: begin
        rdata_d = 32'b0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; a store commits on the edge leaving S_ACCESS.
  always_ff @(posedge clk) begin
    if (state_q == S_ACCESS && wen_q) begin
      for (int i = 0; i < 4; i++) begin
        if (store_be[i]) ram[idx][8*i +: 8] <= store_word[8*i +: 8];
      end
    end
  end

  assign mem_ack    = (state_q == S_RESP);
  assign read_data  = mem_ack ? rdata_q : 32'b0;
  assign addr_error = mem_ack & err_q;

endmodule
